comet_ii_ram_io: RTL and testbench

COMET_II_RAM_IO -- requirements
Module: comet_ii_ram_io

---
 rtl/comet_ii_ram_io_if.sv | 22 ++
 rtl/comet_ii_ram_io.sv | 99 +++++++++
 tb/tb_comet_ii_ram_io.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/comet_ii_ram_io_if.sv
// CPU read/write strobes and console TX stream between the CPU side and comet_ii_ram_io.
interface comet_ii_ram_io_if;
  logic        re;
  logic [15:0] raddr;
  logic [15:0] rdata;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;

  modport master (
    output re, raddr, we, waddr, wdata, tx_ready,
    input  rdata, tx_valid, tx_data
  );

  modport slave (
    input  re, raddr, we, waddr, wdata, tx_ready,
    output rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/comet_ii_ram_io.sv
// Word RAM plus memory-mapped console TX queue (TXDATA FFF0h, TXSTAT FFF1h); 1-cycle registered reads.
// Optional macro RAM_IO_WR_FWD_EN: same-edge read/write of one RAM word returns the new data.
module comet_ii_ram_io #(
  parameter int RAM_AW    = 8,
  parameter int TXQ_DEPTH = 8
) (
  input  logic mclk,
  input  logic init,
  comet_ii_ram_io_if.slave bus
);

  localparam int          PW       = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam logic [16:0] RAM_LIM  = 17'(1) << RAM_AW;
  localparam logic [15:0] A_TXDATA = 16'hFFF0;
  localparam logic [15:0] A_TXSTAT = 16'hFFF1;
  localparam logic [4:0]  Q_FULL   = 5'(TXQ_DEPTH);

  logic [15:0]   ram_mem [1 << RAM_AW];
  logic [15:0]   q_mem   [TXQ_DEPTH];

  logic [15:0]   rdata_q, rdata_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;

  logic rd_ram, wr_ram, rd_stat, push_req, push, pop, full, empty, ovf_set;
  logic [15:0] stat_word;

  assign rd_ram   = ({1'b0, bus.raddr} < RAM_LIM);
  assign wr_ram   = ({1'b0, bus.waddr} < RAM_LIM);
  assign rd_stat  = (bus.raddr == A_TXSTAT);
  assign full     = (count_q == Q_FULL);
  assign empty    = (count_q == 5'd0);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = bus.we && (bus.waddr == A_TXDATA);
  // A full queue still takes the word if the head leaves at the same edge.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign stat_word = {8'h00, count_q[3:0], 1'b0, ovf_q, empty, full};

  assign bus.rdata    = rdata_q;
  assign bus.tx_valid = !empty;
  assign bus.tx_data  = q_mem[rptr_q];

  always_comb begin
    rdata_d = rdata_q;
    if (bus.re) begin
      if (rd_ram) begin
        rdata_d = ram_mem[bus.raddr[RAM_AW-1:0]];
`ifdef RAM_IO_WR_FWD_EN
        if (bus.we && (bus.waddr == bus.raddr)) rdata_d = bus.wdata;
`endif
      end else if (rd_stat) begin
        rdata_d = stat_word;
      end else begin
        rdata_d = 16'h0000;
      end
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 5'd1;
    else if (pop && !push) count_d = count_q - 5'd1;
    // A fresh overflow beats the clear-on-read of TXSTAT.
    if (ovf_set)            ovf_d = 1'b1;
    else if (bus.re && rd_stat) ovf_d = 1'b0;
  end

  always_ff @(posedge mclk or negedge init) begin
    if (!init) begin
      rdata_q <= 16'h0000;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 5'd0;
      ovf_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; the write enable is qualified by init so strobes in reset are dropped.
  always_ff @(posedge mclk) begin
    if (init && bus.we && wr_ram) ram_mem[bus.waddr[RAM_AW-1:0]] <= bus.wdata;
    if (init && push)             q_mem[wptr_q] <= bus.wdata;
  end

endmodule

// File: tb/tb_comet_ii_ram_io.sv
// Directed bench for comet_ii_ram_io: RAM access, address map, TX queue flow and reset.
module tb_comet_ii_ram_io;
  logic mclk = 1'b0;
  logic init = 1'b0;
  int   checks = 0;
  int   errors = 0;

  comet_ii_ram_io_if bus();

  comet_ii_ram_io dut (
    .mclk (mclk),
    .init (init),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  task automatic idle();
    bus.re    = 1'b0;
    bus.we    = 1'b0;
    bus.raddr = 16'h0000;
    bus.waddr = 16'h0000;
    bus.wdata = 16'h0000;
  endtask

  task automatic step();
    @(posedge mclk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    step();
  endtask

  task automatic rd(input logic [15:0] a);
    bus.re = 1'b1; bus.raddr = a;
    step();
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    bus.tx_ready = 1'b0;
    bus.we = 1'b1; bus.waddr = 16'hFFF0; bus.wdata = 16'h00EE;
    #12;
    chk16("reset_rdata", bus.rdata, 16'h0000);
    chk16("reset_tx_valid", {15'd0, bus.tx_valid}, 16'h0000);
    idle();
    @(negedge mclk);
    init = 1'b1;
    rd(16'hFFF1);
    chk16("reset_txstat", bus.rdata, 16'h0002);
  endtask

  task automatic test_ram_rw();
    wr(16'h0010, 16'h1234);
    rd(16'h0010);
    chk16("ram_read", bus.rdata, 16'h1234);
    step();
    chk16("ram_hold", bus.rdata, 16'h1234);
    wr(16'h00FF, 16'hBEEF);
    rd(16'h00FF);
    chk16("ram_top_word", bus.rdata, 16'hBEEF);
  endtask

  task automatic test_fwd();
    wr(16'h0020, 16'hABCD);
    bus.re = 1'b1; bus.raddr = 16'h0020;
    bus.we = 1'b1; bus.waddr = 16'h0020; bus.wdata = 16'h5555;
    step();
`ifdef RAM_IO_WR_FWD_EN
    chk16("same_edge_rw", bus.rdata, 16'h5555);
`else
    chk16("same_edge_rw", bus.rdata, 16'hABCD);
`endif
    rd(16'h0020);
    chk16("after_rw", bus.rdata, 16'h5555);
  endtask

  task automatic test_unmapped();
    wr(16'h0000, 16'h1111);
    rd(16'h0000);
    chk16("ram_word0", bus.rdata, 16'h1111);
    wr(16'h0200, 16'h7777);
    wr(16'hFFF1, 16'h7777);
    rd(16'h0200);
    chk16("unmapped_read", bus.rdata, 16'h0000);
    rd(16'h0000);
    rd(16'hFFF0);
    chk16("txdata_read", bus.rdata, 16'h0000);
    rd(16'h0000);
    chk16("unmapped_write_no_alias", bus.rdata, 16'h1111);
    rd(16'hFFF1);
    chk16("unmapped_write_no_queue", bus.rdata, 16'h0002);
  endtask

  task automatic test_overflow();
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) wr(16'hFFF0, 16'(i));
    chk16("full_head", bus.tx_data, 16'h0001);
    rd(16'hFFF1);
    chk16("txstat_ovf", bus.rdata, 16'h0085);
    rd(16'hFFF1);
    chk16("txstat_ovf_cleared", bus.rdata, 16'h0081);
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_q [8];
    bus.tx_ready = 1'b1;
    wr(16'hFFF0, 16'h00AA);
    bus.tx_ready = 1'b0;
    rd(16'hFFF1);
    chk16("full_push_pop_stat", bus.rdata, 16'h0081);
    for (int i = 0; i < 7; i++) exp_q[i] = 16'(i + 2);
    exp_q[7] = 16'h00AA;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk16($sformatf("drain_%0d", i), bus.tx_data, exp_q[i]);
      step();
    end
    chk16("drained_valid", {15'd0, bus.tx_valid}, 16'h0000);
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_no_bypass();
    bus.tx_ready = 1'b1;
    bus.re = 1'b1; bus.raddr = 16'hFFF1;
    bus.we = 1'b1; bus.waddr = 16'hFFF0; bus.wdata = 16'h00BB;
    step();
    chk16("concurrent_stat", bus.rdata, 16'h0002);
    chk16("no_bypass_valid", {15'd0, bus.tx_valid}, 16'h0001);
    chk16("no_bypass_data", bus.tx_data, 16'h00BB);
    wr(16'hFFF0, 16'h00CC);
    chk16("push_pop_head", bus.tx_data, 16'h00CC);
    bus.tx_ready = 1'b0;
    rd(16'hFFF1);
    chk16("push_pop_count", bus.rdata, 16'h0010);
    bus.tx_ready = 1'b1;
    step();
    chk16("pop_last_valid", {15'd0, bus.tx_valid}, 16'h0000);
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) wr(16'hFFF0, 16'(16'h0100 + i));
    rd(16'h0010);
    chk16("pre_reset_rdata", bus.rdata, 16'h1234);
    #2 init = 1'b0;
    #1;
    chk16("mid_reset_valid", {15'd0, bus.tx_valid}, 16'h0000);
    chk16("mid_reset_rdata", bus.rdata, 16'h0000);
    #2 init = 1'b1;
    rd(16'hFFF1);
    chk16("post_reset_stat", bus.rdata, 16'h0002);
    rd(16'h0010);
    chk16("post_reset_ram", bus.rdata, 16'h1234);
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_fwd();
    test_unmapped();
    test_overflow();
    test_full_push_pop();
    test_no_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
